// File: rtl/fifo_averager.sv
// fifo_averager: pops 12-bit samples from the sample FIFO, sums blocks of
// 2^LOG2_AVG consecutive samples and presents each block's floor average on a
// valid/ready port. Decimates the sample stream by N = 2^LOG2_AVG.
module fifo_averager #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_AVG   = 2,
    parameter int ACC_WIDTH  = DATA_WIDTH + LOG2_AVG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] avg_data,
    output logic                  avg_valid,
    input  logic                  avg_ready,
    output logic                  busy
);

    // Counters must be able to hold the value N itself, hence the extra bit.
    localparam int CNT_WIDTH = LOG2_AVG + 1;
    localparam logic [CNT_WIDTH-1:0] N_CNT    = CNT_WIDTH'(1 << LOG2_AVG);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'((1 << LOG2_AVG) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    logic [1:0]            state_reg,    state_next;
    logic [ACC_WIDTH-1:0]  acc_reg,      acc_next;
    logic [CNT_WIDTH-1:0]  req_cnt_reg,  req_cnt_next;
    logic [CNT_WIDTH-1:0]  rcv_cnt_reg,  rcv_cnt_next;
    logic                  pend_reg,     pend_next;
    logic [DATA_WIDTH-1:0] avg_data_reg, avg_data_next;

    logic [ACC_WIDTH-1:0]  sum;
    logic [ACC_WIDTH-1:0]  sum_shifted;

    // Pop whenever accumulating, data is available and the block still needs samples.
    assign fifo_rd_en = (state_reg == ACCUM) && !fifo_empty && (req_cnt_reg != N_CNT);

    assign avg_valid  = (state_reg == EMIT);
    assign avg_data   = avg_data_reg;
    assign busy       = (state_reg == EMIT) || (rcv_cnt_reg != '0) || pend_reg;

    // Running sum including the sample currently on the FIFO read port.
    assign sum         = acc_reg + ACC_WIDTH'(fifo_data);
    assign sum_shifted = sum >> LOG2_AVG;

    // Next-state logic: issue pops, capture returning samples, finish blocks.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        req_cnt_next  = req_cnt_reg;
        rcv_cnt_next  = rcv_cnt_reg;
        avg_data_next = avg_data_reg;
        // FIFO read data is registered, so a pop returns data one cycle later.
        pend_next     = fifo_rd_en;

        if (fifo_rd_en) begin
            req_cnt_next = req_cnt_reg + CNT_ONE;
        end

        case (state_reg)
            IDLE: begin
                state_next = ACCUM;
            end
            ACCUM: begin
                if (pend_reg) begin
                    if (rcv_cnt_reg == LAST_CNT) begin
                        // Final sample of the block: latch the average and start over.
                        avg_data_next = sum_shifted[DATA_WIDTH-1:0];
                        acc_next      = '0;
                        req_cnt_next  = '0;
                        rcv_cnt_next  = '0;
                        state_next    = EMIT;
                    end else begin
                        acc_next     = sum;
                        rcv_cnt_next = rcv_cnt_reg + CNT_ONE;
                    end
                end
            end
            EMIT: begin
                // No pops are issued here, so no capture can collide with the handshake.
                if (avg_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial block immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            req_cnt_reg  <= '0;
            rcv_cnt_reg  <= '0;
            pend_reg     <= 1'b0;
            avg_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            req_cnt_reg  <= req_cnt_next;
            rcv_cnt_reg  <= rcv_cnt_next;
            pend_reg     <= pend_next;
            avg_data_reg <= avg_data_next;
        end
    end

endmodule

// File: doc/fifo_averager.md
# fifo_averager

Downstream consumer of the 12-bit sample FIFO. Pops samples through the FIFO's `rd_en`/`empty` interface and sums blocks of 2^LOG2_AVG consecutive samples. For each block it presents the floor average on a valid/ready output port. It sits between the sample FIFO and the processing/transmit logic, decimating the sample stream by N = 2^LOG2_AVG.

## Interface
- `DATA_WIDTH`, 12: sample width, equal to the FIFO data width.
- `LOG2_AVG`, 2: log2 of the block size N. Legal range is 0..8. 0 means pass-through.
- `ACC_WIDTH`, DATA_WIDTH+LOG2_AVG: accumulator width. It cannot overflow.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `fifo_data`  in  DATA_WIDTH  FIFO read data. It is registered and valid on the cycle after a pop.
- `avg_data`  out  DATA_WIDTH  block average, equal to sum >> LOG2_AVG (truncated).
- `avg_valid`  out  1  `avg_data` holds a result.
- `avg_ready`  in  1  downstream accepts the result.
- `busy`  out  1  high while a block is partially accumulated or a result is pending.

## Operation
- States:
  - IDLE: entered on reset. Exits to ACCUM on the first clock after `rst_n` deasserts.
  - ACCUM: collecting samples.
  - EMIT: holding a result.
- `fifo_rd_en` is combinational: state==ACCUM && !fifo_empty && req_cnt != N. It is never asserted in IDLE or EMIT.
- `req_cnt` (LOG2_AVG+1 bits) increments on every cycle with `fifo_rd_en`=1.
- `pend` is a register that takes the value of `fifo_rd_en` each cycle. When `pend`=1, `fifo_data` is a fresh sample:
  - acc <= acc + fifo_data.
  - rcv_cnt increments.
- On the capture edge where rcv_cnt reaches N:
  - avg_data <= (acc + fifo_data) >> LOG2_AVG.
  - acc, req_cnt and rcv_cnt clear to 0.
  - State goes to EMIT.
- EMIT:
  - `avg_valid`=1, and `avg_data` is held stable.
  - On avg_valid && avg_ready, the state returns to ACCUM on the same edge.
  - `avg_valid` drops, or reasserts if this was the final capture of the next block. That case cannot occur, because no reads are issued in EMIT.
- Arithmetic:
  - Unsigned.
  - Sum width is ACC_WIDTH.
  - Rounding is floor; no rounding-up.
- Empty gaps: `fifo_rd_en` simply stays low. Partial sums are retained indefinitely and there is no timeout.
- `busy` = (state==EMIT) || (rcv_cnt != 0) || `pend`.

## Timing
- Reset values:
  - state=IDLE; acc, req_cnt, rcv_cnt and pend = 0.
  - avg_data=0, avg_valid=0, busy=0, fifo_rd_en=0.
- Read latency: a pop issued in cycle c is captured at the end of cycle c+1.
- Back-to-back pops are allowed, giving one sample per cycle sustained throughput in ACCUM.
- Latency: `avg_valid` rises at the cycle after the last pop cycle plus 1. With pops in cycles 0..N-1, `avg_valid` is high from cycle N+1.
- Best-case block period is N+2 cycles: N pops, 1 capture drain, and at least 1 EMIT cycle.
- Backpressure: while avg_valid && !avg_ready, `avg_data` is stable and no pops are issued.
- The FIFO's own `!empty` gating is redundant but harmless. This block never pops when `fifo_empty`=1.
- Reset mid-operation:
  - All partial state is discarded immediately.
  - `avg_valid` drops asynchronously.
  - A sample in flight at reset is lost. The FIFO is reset on the same `rst_n`.
- LOG2_AVG=0: every sample is emitted unchanged, with 2-cycle latency from its pop.

## Test plan
- N=4, FIFO preloaded with 100, 200, 300, 400, `avg_ready`=1 -> `fifo_rd_en` high for 4 consecutive cycles, then `avg_valid` pulses once with `avg_data`=250.
- Floor rounding: samples 1, 1, 1, 2 (sum 5) -> `avg_data`=1. Samples 4095×4 -> `avg_data`=4095 with no overflow (acc reaches 16380).
- Empty gaps: push one sample every 7 cycles, values 8, 16, 24, 32 -> exactly 4 pops. `busy` stays high between them. Single result = 20.
- Backpressure: hold `avg_ready`=0 for 10 cycles after `avg_valid` rises, with 8 more samples queued -> `avg_data` stable, `fifo_rd_en`=0 throughout. After ready, the next block yields the correct average.
- Reset mid-block: after 2 of 4 samples (10, 20), pulse `rst_n` low for 1 cycle, then push 4, 4, 4, 4 -> all outputs at reset values during reset. The next result is 4, not contaminated by 10/20.
- LOG2_AVG=0 build: stream 0x123, 0xABC with `avg_ready`=1 -> two results equal to the inputs, each valid 2 cycles after its pop.
